ir_cmd_queue: RTL and testbench

Parametrised command capture stage between `ir_receiver` and its consumers (`led_mgr`, `command_display`). It edge-detects the receiver's level-type ready strobe and latches each new command. Identical repeats inside a configurable window are optionally suppressed. Accepted commands are buffered in a DEPTH-entry FIFO with a valid/ready drain port, so bursts of IR frames are not lost while a consumer is busy.

---
 rtl/ir_cmd_queue_if.sv | 21 ++
 rtl/ir_cmd_queue.sv | 102 ++++++++++
 tb/tb_ir_cmd_queue.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ir_cmd_queue_if.sv
// Receiver-to-queue capture signals and the consumer drain handshake of ir_cmd_queue.
// master = receiver/consumer side, slave = the queue itself.
interface ir_cmd_queue_if #(
   parameter int unsigned DATA_W = 12
);
   logic [DATA_W-1:0] in_data;
   logic              in_rdy;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output in_data, in_rdy, out_ready,
      input  out_data, out_valid
   );

   modport slave (
      input  in_data, in_rdy, out_ready,
      output out_data, out_valid
   );
endinterface

// File: rtl/ir_cmd_queue.sv
// IR command capture: rising-edge detect on the receiver ready level, optional
// repeat suppression, and a DEPTH-entry FIFO with a valid/ready drain port.
module ir_cmd_queue #(
   parameter int unsigned DATA_W        = 12,
   parameter int unsigned DEPTH         = 4,
   parameter int unsigned REPEAT_CYCLES = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   ir_cmd_queue_if.slave              bus,
   output logic [DATA_W-1:0]          last_cmd,
   output logic                       new_cmd,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   input  logic                       ovf_clr
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic              rdy_q;
   logic              capture;
   logic              repeat_drop;
   logic              accept;
   logic              pop;
   logic              slot;
   logic              push;

   assign capture = bus.in_rdy & ~rdy_q;
   assign accept  = capture & ~repeat_drop;
   assign pop     = bus.out_valid & bus.out_ready;
   // A full FIFO still takes a command when the head leaves in the same cycle.
   assign slot    = (count != CW'(DEPTH)) | pop;
   assign push    = accept & slot;

   assign bus.out_valid = (count != '0);
   assign bus.out_data  = mem[rd_ptr];

   generate
      if (REPEAT_CYCLES > 0) begin : g_hold
         localparam int unsigned HW = $clog2(REPEAT_CYCLES+1);
         logic [HW-1:0] hold;

         assign repeat_drop = (bus.in_data == last_cmd) && (hold != '0);

         // Dropped repeats also reload, so a held-down key stays suppressed.
         always_ff @(posedge clk) begin
            if (rst) begin
               hold <= '0;
            end else if (capture) begin
               hold <= HW'(REPEAT_CYCLES);
            end else if (hold != '0) begin
               hold <= hold - HW'(1);
            end
         end
      end else begin : g_no_hold
         assign repeat_drop = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_q    <= 1'b1;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         new_cmd  <= 1'b0;
         last_cmd <= '0;
         overflow <= 1'b0;
      end else begin
         rdy_q   <= bus.in_rdy;
         new_cmd <= accept;
         if (accept) begin
            last_cmd <= bus.in_data;
         end
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
         if (accept && !slot) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ir_cmd_queue.sv
// Self-checking bench for ir_cmd_queue (DEPTH=4, REPEAT_CYCLES=100): capture table,
// hand-written repeat/reset sequences, and a scoreboard checking drained data order.
module tb_ir_cmd_queue;
   localparam int unsigned DW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          ovf_clr;
   logic          new_cmd;
   logic          overflow;
   logic [DW-1:0] last_cmd;
   logic [2:0]    count;
   logic [DW-1:0] model_last;
   logic [DW-1:0] sb [$];
   int            n_checks = 0;
   int            n_fail   = 0;

   always #5 clk = ~clk;

   ir_cmd_queue_if #(.DATA_W(DW)) bus ();

   ir_cmd_queue #(
      .DATA_W        (DW),
      .DEPTH         (4),
      .REPEAT_CYCLES (100)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .last_cmd (last_cmd),
      .new_cmd  (new_cmd),
      .count    (count),
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
   );

   typedef struct {
      logic [DW-1:0] d;
      logic          rdy;
      logic          clr;
      logic          exp_new;
      logic          exp_push;
      logic [2:0]    exp_count;
      logic          exp_ovf;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int unsigned n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard: any head the DUT hands over must be the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: got 0x%0h, expected no data", bus.out_data);
         end else begin
            check("pop_data", 32'(bus.out_data), 32'(sb.pop_front()));
         end
      end
   end

   task automatic capture(input logic [DW-1:0] d, input logic rdy, input logic clr,
                          input logic exp_new, input logic exp_push, input string tag);
      bus.in_data   = d;
      bus.in_rdy    = 1'b1;
      bus.out_ready = rdy;
      ovf_clr       = clr;
      if (exp_push) sb.push_back(d);
      if (exp_new) model_last = d;
      step();
      bus.in_rdy    = 1'b0;
      bus.out_ready = 1'b0;
      ovf_clr       = 1'b0;
      check({tag, ".new_cmd"}, 32'(new_cmd), 32'(exp_new));
      check({tag, ".last_cmd"}, 32'(last_cmd), 32'(model_last));
      step();
      check({tag, ".new_cmd_end"}, 32'(new_cmd), 32'd0);
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         capture(tbl[i].d, tbl[i].rdy, tbl[i].clr, tbl[i].exp_new, tbl[i].exp_push,
                 $sformatf("row%0d", i));
         check($sformatf("row%0d.count", i), 32'(count), 32'(tbl[i].exp_count));
         check($sformatf("row%0d.overflow", i), 32'(overflow), 32'(tbl[i].exp_ovf));
      end
   endtask

   task automatic drain(input int unsigned n);
      bus.out_ready = 1'b1;
      step(n);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      //         d        rdy   clr   new   push  count  ovf
      tbl[0]  = '{12'h001, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0};
      tbl[1]  = '{12'h002, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0};
      tbl[2]  = '{12'h003, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0};
      tbl[3]  = '{12'h004, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0};
      tbl[4]  = '{12'h005, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1};
      tbl[5]  = '{12'h0A1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0};
      tbl[6]  = '{12'h0A2, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0};
      tbl[7]  = '{12'h0A3, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0};
      tbl[8]  = '{12'h0A4, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0};
      tbl[9]  = '{12'h0F0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0};
      tbl[10] = '{12'h0B5, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1};

      rst           = 1'b1;
      bus.in_rdy    = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      ovf_clr       = 1'b0;
      model_last    = '0;
      step(3);
      check("rst.count", 32'(count), 32'd0);
      check("rst.out_valid", 32'(bus.out_valid), 32'd0);
      check("rst.new_cmd", 32'(new_cmd), 32'd0);
      check("rst.last_cmd", 32'(last_cmd), 32'd0);
      check("rst.overflow", 32'(overflow), 32'd0);
      rst = 1'b0;
      step();

      // Single command with in_rdy held high for 6 cycles: one pulse only.
      bus.in_data = 12'hA5C;
      bus.in_rdy  = 1'b1;
      sb.push_back(12'hA5C);
      model_last = 12'hA5C;
      step();
      check("single.new_cmd", 32'(new_cmd), 32'd1);
      check("single.last_cmd", 32'(last_cmd), 32'hA5C);
      check("single.count", 32'(count), 32'd1);
      check("single.out_valid", 32'(bus.out_valid), 32'd1);
      check("single.out_data", 32'(bus.out_data), 32'hA5C);
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("single.held%0d", i), 32'(new_cmd), 32'd0);
      end
      bus.in_rdy = 1'b0;
      step();
      drain(1);
      check("single.drained_count", 32'(count), 32'd0);
      check("single.drained_valid", 32'(bus.out_valid), 32'd0);

      // Overflow on the fifth command, ordered drain, then clear.
      run_rows(0, 4);
      drain(4);
      check("ovf.drained_count", 32'(count), 32'd0);
      check("ovf.sticky", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("ovf.cleared", 32'(overflow), 32'd0);

      // Full FIFO: push with simultaneous pop, then a drop coincident with ovf_clr.
      run_rows(5, 10);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("ovfclr.alone", 32'(overflow), 32'd0);
      drain(4);
      check("full.drained_count", 32'(count), 32'd0);
      check("full.sb_empty", 32'(sb.size()), 32'd0);

      // Repeat window: 0x123 at t=0,50,120,230, then the exact window edges.
      capture(12'h123, 1'b0, 1'b0, 1'b1, 1'b1, "rep_t0");
      step(48);
      capture(12'h123, 1'b0, 1'b0, 1'b0, 1'b0, "rep_t50");
      step(68);
      capture(12'h123, 1'b0, 1'b0, 1'b0, 1'b0, "rep_t120");
      step(108);
      capture(12'h123, 1'b0, 1'b0, 1'b1, 1'b1, "rep_t230");
      step(98);
      capture(12'h123, 1'b0, 1'b0, 1'b0, 1'b0, "rep_win_last");
      step(99);
      capture(12'h123, 1'b0, 1'b0, 1'b1, 1'b1, "rep_win_past");
      step(8);
      capture(12'h456, 1'b0, 1'b0, 1'b1, 1'b1, "rep_other");
      check("rep.count", 32'(count), 32'd4);
      check("rep.overflow", 32'(overflow), 32'd0);
      drain(4);
      check("rep.drained_count", 32'(count), 32'd0);

      // Reset during a capture with in_rdy still high on release.
      capture(12'h321, 1'b0, 1'b0, 1'b1, 1'b1, "pre_rst");
      bus.in_data = 12'h777;
      bus.in_rdy  = 1'b1;
      rst         = 1'b1;
      sb.delete();
      model_last = '0;
      step(3);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("rst_hi.new_cmd%0d", i), 32'(new_cmd), 32'd0);
      end
      check("rst_hi.count", 32'(count), 32'd0);
      check("rst_hi.out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_hi.last_cmd", 32'(last_cmd), 32'd0);
      bus.in_rdy = 1'b0;
      step();
      capture(12'h777, 1'b0, 1'b0, 1'b1, 1'b1, "post_rst");
      check("post_rst.count", 32'(count), 32'd1);
      drain(1);
      check("post_rst.drained", 32'(count), 32'd0);
      check("end.sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected test completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
